// File: rtl/dmem_arb.sv
// Data-memory arbiter: core vs DMA onto one single-port RAM.
// Ports: clk, reset (sync, active-low); core c_* and DMA d_* request/grant/read
// ports; mem_* RAM strobe/address/data; err sticky out-of-range flag.
module dmem_arb #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]  starve;
  logic        force_d;
  logic        any_gnt;
  logic        sel_we;
  logic        in_range;
  logic [31:0] sel_addr;
  logic        rv_c;
  logic        rv_d;
  logic        rd_oor;
  logic        unused;

  // DMA has waited long enough: it takes this cycle even over the core.
  assign force_d = d_req && (starve == SMAX);

  assign c_gnt   = reset && c_req && !force_d;
  assign d_gnt   = reset && d_req && (force_d || !c_req);
  assign any_gnt = c_gnt || d_gnt;

  assign sel_addr  = d_gnt ? d_addr  : c_addr;
  assign sel_we    = d_gnt ? d_we    : c_we;
  assign mem_wdata = d_gnt ? d_wdata : c_wdata;
  assign mem_addr  = sel_addr[ADDR_W+1:2];
  assign in_range  = (sel_addr[31:ADDR_W+2] == '0);

  // Out-of-range accesses are still granted, but never reach the RAM.
  assign mem_en = any_gnt && in_range;
  assign mem_we = mem_en && sel_we;

  assign unused = ^sel_addr[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve <= '0;
      rv_c   <= 1'b0;
      rv_d   <= 1'b0;
      rd_oor <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (d_req && !d_gnt)
        starve <= (starve == SMAX) ? starve : starve + 4'd1;
      else
        starve <= '0;
      rv_c   <= c_gnt && !c_we;
      rv_d   <= d_gnt && !d_we;
      rd_oor <= !in_range;
      if (any_gnt && !in_range)
        err <= 1'b1;
    end
  end

  // Read return is squashed while reset is held so a read in flight
  // when reset arrives never shows up.
  assign c_rvalid = rv_c && reset;
  assign d_rvalid = rv_d && reset;
  assign c_rdata  = (c_rvalid && !rd_oor) ? mem_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && !rd_oor) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arb.sv
// Testbench for dmem_arb: directed vectors, behavioural model, RAM harness.
// Compares every cycle at negedge plus literal spot checks.
module tb_dmem_arb;

  localparam int AW = 14;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [31:0]   c_addr, c_wdata, d_addr, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0]   c_rdata, d_rdata;
  logic          mem_en, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  int n_pass = 0;
  int n_tot  = 0;

  dmem_arb #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // RAM harness: read data one cycle after the strobe.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [31:0] init_val(int i);
    return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [0:(1<<AW)-1];
  int          starve_m;
  bit          err_m, pc, pd, started;
  logic [31:0] pdat_c, pdat_d;

  function automatic bit oor(logic [31:0] a);
    return longint'(a) >= (longint'(1) << (AW + 2));
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) / 4) % (longint'(1) << AW));
  endfunction

  // 0 = nobody, 1 = core, 2 = DMA
  function automatic int owner();
    if (reset !== 1'b1) return 0;
    if (d_req && starve_m >= SM) return 2;
    if (c_req) return 1;
    if (d_req) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : mdl
    int          o;
    logic [31:0] a, wd, dat;
    bit          w;
    started = 1'b1;
    if (reset !== 1'b1) begin
      starve_m = 0;
      err_m    = 0;
      pc       = 0;
      pd       = 0;
    end else begin
      o  = owner();
      a  = (o == 2) ? d_addr  : c_addr;
      w  = (o == 2) ? d_we    : c_we;
      wd = (o == 2) ? d_wdata : c_wdata;
      if (d_req && o != 2) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
      else starve_m = 0;
      pc = 0;
      pd = 0;
      if (o != 0) begin
        if (oor(a)) err_m = 1;
        if (w) begin
          if (!oor(a)) mm[widx(a)] = wd;
        end else begin
          dat = oor(a) ? 32'h0 : mm[widx(a)];
          if (o == 1) begin pc = 1; pdat_c = dat; end
          else        begin pd = 1; pdat_d = dat; end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int          o;
    logic [31:0] a, wd;
    bit          w, en, rvc, rvd;
    if (started) begin
      o   = owner();
      a   = (o == 2) ? d_addr  : c_addr;
      w   = (o == 2) ? d_we    : c_we;
      wd  = (o == 2) ? d_wdata : c_wdata;
      en  = (o != 0) && !oor(a);
      rvc = pc && (reset === 1'b1);
      rvd = pd && (reset === 1'b1);
      chk("c_gnt", 32'(c_gnt), 32'(o == 1));
      chk("d_gnt", 32'(d_gnt), 32'(o == 2));
      chk("mem_en", 32'(mem_en), 32'(en));
      chk("mem_we", 32'(mem_we), 32'(en && w));
      if (en) begin
        chk("mem_addr", 32'(mem_addr), 32'(widx(a)));
        chk("mem_wdata", mem_wdata, wd);
      end
      chk("c_rvalid", 32'(c_rvalid), 32'(rvc));
      chk("c_rdata", c_rdata, rvc ? pdat_c : 32'h0);
      chk("d_rvalid", 32'(d_rvalid), 32'(rvd));
      chk("d_rdata", d_rdata, rvd ? pdat_d : 32'h0);
      chk("err", 32'(err), 32'(err_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(bit rs, bit cr, bit cw, logic [31:0] ca, logic [31:0] cwd,
                     bit dr, bit dw, logic [31:0] da, logic [31:0] dwd);
    @(posedge clk);
    #1;
    reset = rs;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #2;
  endtask

  task automatic idle(bit rs);
    drv(rs, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] dv, cv;
    logic [2:0] rvs;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = init_val(i);
      mm[i]  = init_val(i);
    end
    reset = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    idle(0);
    idle(0);

    // requests ignored under reset
    drv(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    chk("rst_c_gnt", 32'(c_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);

    // core-only read, granted in first cycle out of reset
    drv(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("core_gnt", 32'(c_gnt), 1);
    chk("core_addr", 32'(mem_addr), 4);
    chk("core_en", 32'(mem_en), 1);
    idle(1);
    chk("core_rv", 32'(c_rvalid), 1);
    chk("core_rd", c_rdata, 32'h5A5E_000C);
    chk("core_drv", 32'(d_rvalid), 0);

    // contention: DMA forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
      dv[i] = d_gnt;
      cv[i] = c_gnt;
    end
    chk("contend_d", 32'(dv), 32'h210);
    chk("contend_c", 32'(cv), 32'h1EF);

    // write then read same word
    drv(1, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 16);
    drv(1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    idle(1);
    chk("wr_rd_rv", 32'(c_rvalid), 1);
    chk("wr_rd_dat", c_rdata, 32'hDEAD_BEEF);
    chk("wr_rd_drv", 32'(d_rvalid), 0);

    // alternating owners, back to back
    drv(1, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 0, 32'hC, 0);
    rvs[0] = c_rvalid;
    drv(1, 1, 0, 32'h14, 0, 0, 0, 0, 0);
    rvs[1] = d_rvalid;
    idle(1);
    rvs[2] = c_rvalid;
    chk("alt_rv", 32'(rvs), 32'h7);
    chk("alt_drd", 32'(d_rvalid), 0);

    // out-of-range read, sticky err
    drv(1, 1, 0, 32'h0001_0000, 0, 0, 0, 0, 0);
    chk("oor_gnt", 32'(c_gnt), 1);
    chk("oor_en", 32'(mem_en), 0);
    idle(1);
    chk("oor_rv", 32'(c_rvalid), 1);
    chk("oor_rd", c_rdata, 32'h0);
    chk("oor_err", 32'(err), 1);
    drv(1, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF0, 32'h1234_5678);
    chk("oor_wr_en", 32'(mem_en), 0);
    chk("oor_wr_we", 32'(mem_we), 0);
    idle(1);
    idle(1);
    chk("err_sticky", 32'(err), 1);

    // reset arrives with a read in flight
    drv(1, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 32'h24, 0, 1, 0, 32'h28, 0);
    chk("rmid_rv", 32'(c_rvalid), 0);
    chk("rmid_cg", 32'(c_gnt), 0);
    chk("rmid_dg", 32'(d_gnt), 0);
    idle(0);
    chk("rmid_err", 32'(err), 0);
    idle(1);
    chk("rpost_rv", 32'(c_rvalid), 0);

    // mixed traffic checked by the model
    for (int i = 0; i < 24; i++) begin
      drv(1, (i % 3) != 0, (i % 4) == 1, 32'(i * 4) + 32'h300, 32'hA000_0000 + 32'(i),
          (i % 2) == 0, (i % 5) == 2, 32'(i * 8) + 32'h300, 32'hB000_0000 + 32'(i));
    end
    idle(1);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the shared data RAM (16384 words).
REQ-002 Parameter STARVE_MAX, default 4, consecutive denied DMA cycles before a forced DMA grant; legal range 1-15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 c_req  input  1  core memory-stage request.
REQ-006 c_we  input  1  core write enable; 0 means read.
REQ-007 c_addr  input  32  core byte address.
REQ-008 c_wdata  input  32  core write data.
REQ-009 c_gnt  output  1  core request accepted this cycle; combinational.
REQ-010 c_rvalid  output  1  core read data valid; registered.
REQ-011 c_rdata  output  32  core read data.
REQ-012 d_req, d_we, d_addr[31:0], d_wdata[31:0]  input  DMA/loader port; same meaning as the core port.
REQ-013 d_gnt, d_rvalid, d_rdata[31:0]  output  DMA port; same meaning as the core port.
REQ-014 mem_en  output  1  RAM access strobe.
REQ-015 mem_we  output  1  RAM write strobe; valid only with mem_en.
REQ-016 mem_addr  output  ADDR_W  RAM word address.
REQ-017 mem_wdata  output  32  RAM write data.
REQ-018 mem_rdata  input  32  RAM read data, valid one cycle after a read strobe.
REQ-019 err  output  1  sticky out-of-range access flag.

Function
REQ-020 Grant is decided combinationally each cycle; at most one of c_gnt and d_gnt is high.
REQ-021 Default priority: core wins whenever c_req=1, except when the forced-DMA condition of REQ-023 holds.
REQ-022 Starve counter (4 bits): increments, saturating at STARVE_MAX, on each cycle with d_req=1 and d_gnt=0; clears on a cycle with d_gnt=1 or d_req=0.
REQ-023 Forced DMA: when the counter equals STARVE_MAX and d_req=1, d_gnt=1 and c_gnt=0 for that cycle, even if c_req=1; the core must hold its request.
REQ-024 The granted port drives mem_we, mem_wdata, and mem_addr = addr[ADDR_W+1:2]; byte-offset bits [1:0] are ignored.
REQ-025 Range check: an access is in range when addr[31:ADDR_W+2]==0.
REQ-026 In-range grant: mem_en=1.
REQ-027 No grant: mem_en=0, mem_we=0.
REQ-028 Out-of-range grant: still granted; mem_en=0; err set on the next edge; err stays set until reset.
REQ-029 Read pipeline: a granted read registers the owner and an out-of-range bit; the next cycle raises the owner's rvalid for exactly one cycle.
REQ-030 rdata during rvalid = mem_rdata for in-range reads, 32'h0 for out-of-range reads; rdata of both ports = 0 when their rvalid=0.
REQ-031 Granted writes never produce rvalid.
REQ-032 Read latency is 1 cycle from grant to rvalid; back-to-back reads, including alternating owners, sustain 1 access/cycle.
REQ-033 A write and a read to the same address on consecutive cycles: the read returns the new data (RAM write-first not required; the arbiter adds no forwarding; the write completes one cycle before the read strobe).

Reset
REQ-034 While reset=0 at a rising edge: starve counter=0, read pipeline cleared, c_rvalid=d_rvalid=0, err=0.
REQ-035 While reset=0: c_gnt=d_gnt=0 and mem_en=mem_we=0 regardless of requests.
REQ-036 A read granted in the cycle before reset asserts produces no rvalid after reset.
REQ-037 First grant is possible in the first cycle with reset=1.

Verification
REQ-038 Core only: c_req=1, c_we=0, c_addr=32'h10 -> c_gnt=1, mem_addr=4, mem_en=1; next cycle c_rvalid=1, c_rdata=mem_rdata; d_rvalid=0.
REQ-039 Contention, STARVE_MAX=4: c_req=d_req=1 held -> c_gnt=1 for cycles 0-3, d_gnt=1 at cycle 4, c_gnt=1 at cycles 5-8, d_gnt=1 at cycle 9.
REQ-040 Write then read: d writes 32'hDEADBEEF to 32'h40, then c reads 32'h40 -> mem_we=1 with mem_addr=16 in the first cycle; c_rvalid carries the RAM output in the third cycle; no d_rvalid.
REQ-041 Out of range: c reads 32'h0001_0000 -> c_gnt=1, mem_en=0; next cycle c_rvalid=1, c_rdata=0, err=1; err remains 1 until reset=0.
REQ-042 Reset mid-read: read granted, reset=0 at the next edge -> c_rvalid=0, counter=0, grants low while reset=0.
REQ-043 Alternating reads c, d, c on consecutive cycles -> rvalid follows one cycle later on c, d, c with no gaps.
